next_pc_predictor: RTL
======================

Name: next_pc_predictor

Overview:
- IF-stage next-PC generator sitting directly upstream of the PC register; drives the register's pc_in every cycle.
- Holds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, indexed by the current fetch PC.
- Selects, in priority order: EX-stage redirect, predicted-taken target, PC+4.
- Exports the prediction so the pipeline can carry it to EX for misprediction detection.

Parameters:
- WIDTH, 32, address/PC width in bits.
- ENTRIES, 16, number of BTB entries; power of two, at least 2.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- pc  input  WIDTH  current fetch PC, taken from the PC register output
- ex_redirect  input  1  EX detected a misprediction; force next_pc to ex_correct_pc
- ex_correct_pc  input  WIDTH  architecturally correct next PC from EX
- ex_update  input  1  EX resolved a control-transfer instruction this cycle; one pulse per instruction
- ex_pc  input  WIDTH  PC of the resolved instruction
- ex_taken  input  1  resolved direction
- ex_target  input  WIDTH  resolved taken target
- next_pc  output  WIDTH  value presented to the PC register's pc_in
- pred_taken  output  1  lookup hit with counter MSB = 1
- pred_target  output  WIDTH  predicted target; pc+4 when pred_taken = 0

Behaviour:
- IDX = log2(ENTRIES).
- Index = pc[IDX+1:2]; tag = pc[WIDTH-1:IDX+2]. The same split applies to ex_pc.
- Entry contents: valid, tag, target, ctr[1:0].
- Storage is flops, not SRAM, so the valid bits can be reset asynchronously.
- Reset: all valid bits = 0, all counters = 2'b01. All other fields are don't-care.
- Outputs are combinational, so next_pc is correct during reset: pc+4, or ex_correct_pc if ex_redirect is high.
- Lookup is combinational, zero latency.
  - hit = valid and (tag matches).
  - pred_taken = hit and ctr[1].
  - pred_target = pred_taken ? stored target : pc + 4.
- next_pc = ex_redirect ? ex_correct_pc : pred_target.
  - ex_redirect always wins over a simultaneous hit.
- PC+4 arithmetic is modulo 2^WIDTH; 0xFFFFFFFC wraps to 0x0.
- Update is synchronous on posedge clk when ex_update = 1.
  - Hit on ex_pc: counter saturates up if taken, down if not taken (11 and 00 saturate). Target is overwritten with ex_target when taken.
  - Miss and taken: allocate or replace the entry. valid = 1, tag and target written, ctr = 2'b10.
  - Miss and not taken: no change.
- Read-during-write: a lookup in the same cycle as an update to that entry sees the old contents. The new contents are visible from the next cycle.
- Table updates ignore the PC register's stall (update_n). EX guarantees a single ex_update pulse per instruction.
- ex_redirect and ex_update are independent and may both be asserted. Both take effect.
- Asynchronous reset asserted mid-operation clears all valid bits immediately. Any pending update in that cycle is discarded.

Optional Feature:
- Macro: BTB_STATS_EN.
- When defined, add 32-bit wrapping counters plus their ports:
  - stat_lookups_taken (output, 32): increments each cycle pred_taken = 1.
  - stat_redirects (output, 32): increments each cycle ex_redirect = 1.
  - Both counters reset to 0.
- When undefined, neither the ports nor the logic exist. Prediction behaviour is identical either way.

Decomposition:
- Package if_pkg holds:
  - btb_entry_t struct (valid, tag, target, ctr).
  - ctr_t 2-bit type.
  - Constants CTR_RESET = 2'b01, CTR_ALLOC = 2'b10.
  - Constant PC_STEP = 4.
- One sub-module, sat_counter2: combinational next-count from (ctr, taken). Instantiated once on the update path.

Test Plan (ENTRIES = 16):
- After reset, pc = 0x100 -> next_pc = 0x104, pred_taken = 0.
- ex_update with ex_pc = 0x100, taken, target 0x200; next cycle pc = 0x100 -> next_pc = 0x200, pred_taken = 1.
- Drive three further taken updates at 0x100, then one not-taken -> still pred_taken = 1 (ctr 11->10). A second not-taken -> next_pc = 0x104.
- Aliasing: with 0x100 allocated, lookup pc = 0x140 (same index, different tag) -> next_pc = 0x144.
  - Taken update at 0x140 with target 0x300 replaces the entry.
  - Afterwards pc = 0x100 -> 0x104 and pc = 0x140 -> 0x300.
- With 0x100 hitting as taken, assert ex_redirect with ex_correct_pc = 0x400 -> next_pc = 0x400 in the same cycle.
  - Also: update in the same cycle as a lookup of that entry -> old prediction that cycle, new prediction the next.
- Assert reset asynchronously between clock edges after several allocations -> pc = 0x100 gives next_pc = 0x104 immediately. pc = 0xFFFFFFFC gives 0x0.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the IF-stage next-PC predictor.
package if_pkg;

  // Storage width for BTB tag/target fields; large enough for any supported WIDTH.
  localparam int unsigned PC_MAX_W = 64;

  localparam int unsigned PC_STEP = 4;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_RESET = 2'b01;
  localparam ctr_t CTR_ALLOC = 2'b10;

  typedef struct packed {
    logic                valid;
    logic [PC_MAX_W-1:0] tag;
    logic [PC_MAX_W-1:0] target;
    ctr_t                ctr;
  } btb_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating direction counter: next count from current count and outcome.
module sat_counter2
  import if_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  localparam ctr_t CTR_MAX = '1;
  localparam ctr_t CTR_MIN = '0;

  // Step towards strongly-taken / strongly-not-taken, holding at the ends.
  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_MAX) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != CTR_MIN) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/next_pc_predictor.sv
// IF-stage next-PC generator with a direct-mapped BTB (2-bit counters).
// Priority: EX redirect, predicted-taken target, PC+4.
// Optional build macro BTB_STATS_EN adds lookup/redirect statistics counters.
module next_pc_predictor
  import if_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ENTRIES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc,
  input  logic             ex_redirect,
  input  logic [WIDTH-1:0] ex_correct_pc,
  input  logic             ex_update,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic             ex_taken,
  input  logic [WIDTH-1:0] ex_target,
  output logic [WIDTH-1:0] next_pc,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]      stat_lookups_taken,
  output logic [31:0]      stat_redirects
`endif
);

  localparam int unsigned IDX = $clog2(ENTRIES);

  btb_entry_t btb [ENTRIES];

  logic [IDX-1:0]      rd_idx;
  logic [IDX-1:0]      wr_idx;
  logic [PC_MAX_W-1:0] rd_tag;
  logic [PC_MAX_W-1:0] wr_tag;
  btb_entry_t          rd_entry;
  logic                rd_hit;
  logic                wr_hit;
  logic [WIDTH-1:0]    pc_plus;
  logic [1:0]          ctr_next;
  logic                unused_ok;

  // Byte-offset bits of the PCs carry no information for the BTB.
  assign unused_ok = &{1'b0, pc[1:0], ex_pc[1:0]};

  // Index/tag split of the fetch PC and of the resolving PC.
  assign rd_idx = pc[IDX+1:2];
  assign rd_tag = PC_MAX_W'(pc[WIDTH-1:IDX+2]);
  assign wr_idx = ex_pc[IDX+1:2];
  assign wr_tag = PC_MAX_W'(ex_pc[WIDTH-1:IDX+2]);

  // Zero-latency lookup; reads the pre-update contents during a write.
  always_comb begin
    rd_entry    = btb[rd_idx];
    pc_plus     = pc + WIDTH'(PC_STEP);
    rd_hit      = rd_entry.valid && (rd_entry.tag == rd_tag);
    pred_taken  = rd_hit && rd_entry.ctr[1];
    pred_target = pred_taken ? WIDTH'(rd_entry.target) : pc_plus;
    next_pc     = ex_redirect ? ex_correct_pc : pred_target;
  end

  assign wr_hit = btb[wr_idx].valid && (btb[wr_idx].tag == wr_tag);

  sat_counter2 u_ctr (
    .ctr      (btb[wr_idx].ctr),
    .taken    (ex_taken),
    .ctr_next (ctr_next)
  );

  // Table training from EX; reset clears valid bits and weakens counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        btb[i].valid <= 1'b0;
        btb[i].ctr   <= CTR_RESET;
      end
    end else if (ex_update) begin
      if (wr_hit) begin
        btb[wr_idx].ctr <= ctr_next;
        if (ex_taken) btb[wr_idx].target <= PC_MAX_W'(ex_target);
      end else if (ex_taken) begin
        btb[wr_idx] <= '{valid: 1'b1, tag: wr_tag, target: PC_MAX_W'(ex_target), ctr: CTR_ALLOC};
      end
    end
  end

`ifdef BTB_STATS_EN
  // Free-running wrapping statistics counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_lookups_taken <= '0;
      stat_redirects     <= '0;
    end else begin
      if (pred_taken)  stat_lookups_taken <= stat_lookups_taken + 32'd1;
      if (ex_redirect) stat_redirects     <= stat_redirects + 32'd1;
    end
  end
`endif

endmodule
